// File: rtl/alu_pkg.sv
// Shared opcodes, slice controls and FSM encoding for the bit-serial ALU.
package alu_pkg;

  localparam logic [3:0] ALU_CTRL_AND = 4'b0000;
  localparam logic [3:0] ALU_CTRL_OR  = 4'b0001;
  localparam logic [3:0] ALU_CTRL_ADD = 4'b0010;
  localparam logic [3:0] ALU_CTRL_SUB = 4'b0110;
  localparam logic [3:0] ALU_CTRL_SLT = 4'b0111;
  localparam logic [3:0] ALU_CTRL_NOR = 4'b1100;

  localparam logic [1:0] ALU_OP_AND  = 2'b00;
  localparam logic [1:0] ALU_OP_OR   = 2'b01;
  localparam logic [1:0] ALU_OP_ADD  = 2'b10;
  localparam logic [1:0] ALU_OP_LESS = 2'b11;

  typedef logic [1:0] state_t;
  localparam state_t S_IDLE = 2'd0;
  localparam state_t S_RUN  = 2'd1;
  localparam state_t S_DONE = 2'd2;

  typedef struct packed {
    logic       a_invert;
    logic       b_invert;
    logic       cin0;
    logic [1:0] operation;
  } slice_ctrl_t;

  function automatic slice_ctrl_t alu_decode(input logic [3:0] ctrl);
    slice_ctrl_t c;
    case (ctrl)
      ALU_CTRL_AND: c = '{1'b0, 1'b0, 1'b0, ALU_OP_AND};
      ALU_CTRL_OR:  c = '{1'b0, 1'b0, 1'b0, ALU_OP_OR};
      ALU_CTRL_ADD: c = '{1'b0, 1'b0, 1'b0, ALU_OP_ADD};
      ALU_CTRL_SUB: c = '{1'b0, 1'b1, 1'b1, ALU_OP_ADD};
      ALU_CTRL_SLT: c = '{1'b0, 1'b1, 1'b1, ALU_OP_ADD};
      ALU_CTRL_NOR: c = '{1'b1, 1'b1, 1'b0, ALU_OP_AND};
      default:      c = '{1'b0, 1'b0, 1'b0, ALU_OP_AND};
    endcase
    return c;
  endfunction

  function automatic logic alu_ctrl_supported(input logic [3:0] ctrl);
    return ctrl inside {ALU_CTRL_AND, ALU_CTRL_OR, ALU_CTRL_ADD, ALU_CTRL_SUB, ALU_CTRL_SLT,
                        ALU_CTRL_NOR};
  endfunction

endpackage

// File: rtl/alu_bit_slice.sv
// Combinational 1-bit ALU slice: optional operand inversion, AND/OR/ADD/LESS select.
module alu_bit_slice
  import alu_pkg::*;
(
  input  logic       a_i,
  input  logic       b_i,
  input  logic       cin_i,
  input  logic       a_invert_i,
  input  logic       b_invert_i,
  input  logic [1:0] operation_i,
  input  logic       less_i,
  output logic       result_o,
  output logic       cout_o,
  output logic       set_o
);

  logic a_eff, b_eff, sum;

  always_comb begin
    a_eff  = a_i ^ a_invert_i;
    b_eff  = b_i ^ b_invert_i;
    sum    = a_eff ^ b_eff ^ cin_i;
    cout_o = (a_eff & b_eff) | (a_eff & cin_i) | (b_eff & cin_i);
    set_o  = sum;
    case (operation_i)
      ALU_OP_AND: result_o = a_eff & b_eff;
      ALU_OP_OR:  result_o = a_eff | b_eff;
      ALU_OP_ADD: result_o = sum;
      default:    result_o = less_i;
    endcase
  end

endmodule

// File: rtl/alu_serial_ctrl.sv
// Bit-serial ALU sequencer: one operation stepped LSB first through a 1-bit slice.
// Optional ALU_SERIAL_FLAGS_EN adds zero_o / overflow_o result flags.
module alu_serial_ctrl
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [3:0]       alu_ctrl_i,
  input  logic [WIDTH-1:0] src1_i,
  input  logic [WIDTH-1:0] src2_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
`ifdef ALU_SERIAL_FLAGS_EN
  output logic             zero_o,
  output logic             overflow_o,
`endif
  output logic [WIDTH-1:0] result_o
);

  localparam int unsigned CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] LastBit = CNT_W'(WIDTH - 1);

  state_t           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic [WIDTH-1:0] a_sh_q, b_sh_q, res_q;
  logic             a_inv_q, b_inv_q, slt_q, unsup_q;
  logic [1:0]       op_q;
  slice_ctrl_t      dec;
  logic             slice_res, slice_cout, slice_set, msb_ovf;
  logic [WIDTH-1:0] res_shift;

  alu_bit_slice u_slice (
    .a_i         (a_sh_q[0]),
    .b_i         (b_sh_q[0]),
    .cin_i       (carry_q),
    .a_invert_i  (a_inv_q),
    .b_invert_i  (b_inv_q),
    .operation_i (op_q),
    .less_i      (1'b0),
    .result_o    (slice_res),
    .cout_o      (slice_cout),
    .set_o       (slice_set)
  );

  always_comb begin
    dec       = alu_decode(alu_ctrl_i);
    msb_ovf   = carry_q ^ slice_cout;
    res_shift = {slice_res, res_q[WIDTH-1:1]};
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      carry_q <= 1'b0;
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      res_q   <= '0;
      a_inv_q <= 1'b0;
      b_inv_q <= 1'b0;
      op_q    <= ALU_OP_AND;
      slt_q   <= 1'b0;
      unsup_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid_i) begin
            a_sh_q  <= src1_i;
            b_sh_q  <= src2_i;
            a_inv_q <= dec.a_invert;
            b_inv_q <= dec.b_invert;
            op_q    <= dec.operation;
            carry_q <= dec.cin0;
            slt_q   <= (alu_ctrl_i == ALU_CTRL_SLT);
            unsup_q <= !alu_ctrl_supported(alu_ctrl_i);
            cnt_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_sh_q  <= a_sh_q >> 1;
          b_sh_q  <= b_sh_q >> 1;
          carry_q <= slice_cout;
          if (cnt_q == LastBit) begin
            // MSB cycle: the final result (including SLT fix-up) lands with DONE.
            cnt_q   <= '0;
            state_q <= S_DONE;
            if (unsup_q)    res_q <= '0;
            else if (slt_q) res_q <= {{(WIDTH-1){1'b0}}, slice_set ^ msb_ovf};
            else            res_q <= res_shift;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            res_q <= res_shift;
          end
        end
        S_DONE: begin
          if (out_ready_i) state_q <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready_o  = (state_q == S_IDLE);
  assign out_valid_o = (state_q == S_DONE);
  assign result_o    = res_q;

`ifdef ALU_SERIAL_FLAGS_EN
  logic arith_q, ovf_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      arith_q <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      if (state_q == S_IDLE && in_valid_i) begin
        arith_q <= (alu_ctrl_i == ALU_CTRL_ADD) || (alu_ctrl_i == ALU_CTRL_SUB);
      end
      if (state_q == S_RUN && cnt_q == LastBit) ovf_q <= msb_ovf;
    end
  end

  assign zero_o     = out_valid_o && (res_q == '0);
  assign overflow_o = out_valid_o && arith_q && ovf_q;
`endif

endmodule

// File: tb/tb_alu_serial_ctrl.sv
// Directed self-checking bench for alu_serial_ctrl at WIDTH=8.
module tb_alu_serial_ctrl;

  localparam int unsigned W = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [3:0]   alu_ctrl = 4'b0000;
  logic [W-1:0] src1 = '0;
  logic [W-1:0] src2 = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] result;
`ifdef ALU_SERIAL_FLAGS_EN
  logic         zero;
  logic         overflow;
`endif

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_serial_ctrl #(.WIDTH(W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .in_valid_i  (in_valid),
    .in_ready_o  (in_ready),
    .alu_ctrl_i  (alu_ctrl),
    .src1_i      (src1),
    .src2_i      (src2),
    .out_valid_o (out_valid),
    .out_ready_i (out_ready),
`ifdef ALU_SERIAL_FLAGS_EN
    .zero_o      (zero),
    .overflow_o  (overflow),
`endif
    .result_o    (result)
  );

  // Present a request and return just after the accepting edge.
  task automatic issue(input logic [3:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    @(negedge clk);
    alu_ctrl = op;
    src1     = a;
    src2     = b;
    in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Cycles counted from the request cycle (accept edge = 1) until out_valid is seen.
  task automatic wait_valid(output int n);
    n = 1;
    while (!out_valid && n < 40) begin
      @(posedge clk);
      #1;
      n++;
    end
  endtask

  task automatic consume();
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
    checks++;
    if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    checks++;
    if (result !== 8'h00) begin errors++; $display("FAIL reset_result got=%h exp=00", result); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_add();
    int n;
    issue(4'b0010, 8'h7F, 8'h01);
    wait_valid(n);
    checks++;
    if (n !== 9) begin errors++; $display("FAIL add_latency got=%0d exp=9", n); end
    checks++;
    if (result !== 8'h80) begin errors++; $display("FAIL add_result got=%h exp=80", result); end
`ifdef ALU_SERIAL_FLAGS_EN
    checks++;
    if (overflow !== 1'b1) begin errors++; $display("FAIL add_overflow got=%b exp=1", overflow); end
`endif
    consume();
    checks++;
    if (out_valid !== 1'b0 || in_ready !== 1'b1) begin
      errors++;
      $display("FAIL add_release got valid=%b ready=%b exp valid=0 ready=1", out_valid, in_ready);
    end
  endtask

  task automatic test_ops();
    logic [3:0]   ops [8] = '{4'b0110, 4'b0111, 4'b0111, 4'b0000, 4'b0001, 4'b1100,
                              4'b1111, 4'b0010};
    logic [W-1:0] as  [8] = '{8'h05, 8'h80, 8'h01, 8'hF0, 8'hF0, 8'hF0, 8'hF0, 8'hFF};
    logic [W-1:0] bs  [8] = '{8'h07, 8'h01, 8'h80, 8'h3C, 8'h3C, 8'h3C, 8'h3C, 8'h01};
    logic [W-1:0] exp [8] = '{8'hFE, 8'h01, 8'h00, 8'h30, 8'hFC, 8'h03, 8'h00, 8'h00};
    logic         eov [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    int n;
    for (int i = 0; i < 8; i++) begin
      issue(ops[i], as[i], bs[i]);
      wait_valid(n);
      checks++;
      if (!out_valid || result !== exp[i]) begin
        errors++;
        $display("FAIL op%0d_%b got valid=%b res=%h exp res=%h", i, ops[i], out_valid, result,
                 exp[i]);
      end
`ifdef ALU_SERIAL_FLAGS_EN
      checks++;
      if (zero !== (exp[i] == 8'h00) || overflow !== eov[i]) begin
        errors++;
        $display("FAIL op%0d_flags got z=%b o=%b exp z=%b o=%b", i, zero, overflow,
                 exp[i] == 8'h00, eov[i]);
      end
`else
      if (eov[i]) $display("note: overflow expectation unused without flags");
`endif
      consume();
    end
  endtask

  task automatic test_backpressure();
    int n;
    issue(4'b0010, 8'h12, 8'h34);
    wait_valid(n);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      alu_ctrl = 4'b0001;
      src1     = 8'hAA;
      src2     = 8'h55;
      in_valid = 1'b1;
      checks++;
      if (out_valid !== 1'b1 || result !== 8'h46 || in_ready !== 1'b0) begin
        errors++;
        $display("FAIL hold_c%0d got valid=%b res=%h ready=%b exp valid=1 res=46 ready=0", c,
                 out_valid, result, in_ready);
      end
    end
    @(negedge clk);
    in_valid = 1'b0;
    consume();
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
      errors++;
      $display("FAIL hold_release got ready=%b valid=%b exp ready=1 valid=0", in_ready, out_valid);
    end
  endtask

  task automatic test_ignore_in_run();
    int n;
    issue(4'b0010, 8'h03, 8'h04);
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      alu_ctrl = 4'b0001;
      src1     = 8'h50;
      src2     = 8'h50;
      in_valid = 1'b1;
      checks++;
      if (in_ready !== 1'b0) begin errors++; $display("FAIL run_ready got=%b exp=0", in_ready); end
    end
    @(negedge clk);
    in_valid = 1'b0;
    wait_valid(n);
    checks++;
    if (!out_valid || result !== 8'h07) begin
      errors++;
      $display("FAIL run_ignore got valid=%b res=%h exp res=07", out_valid, result);
    end
    consume();
  endtask

  task automatic test_back_to_back();
    int n;
    issue(4'b0110, 8'h00, 8'h01);
    wait_valid(n);
    checks++;
    if (result !== 8'hFF) begin errors++; $display("FAIL b2b_first got=%h exp=ff", result); end
    consume();
    issue(4'b0010, 8'hC8, 8'h64);
    wait_valid(n);
    checks++;
    if (n !== 9 || result !== 8'h2C) begin
      errors++;
      $display("FAIL b2b_second got lat=%0d res=%h exp lat=9 res=2c", n, result);
    end
    consume();
  endtask

  task automatic test_reset_mid_run();
    int  n;
    logic seen = 1'b0;
    issue(4'b0010, 8'h11, 8'h22);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    checks++;
    if (in_ready !== 1'b1 || out_valid !== 1'b0 || result !== 8'h00) begin
      errors++;
      $display("FAIL abort_state got ready=%b valid=%b res=%h exp 1 0 00", in_ready, out_valid,
               result);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 12; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) seen = 1'b1;
    end
    checks++;
    if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_result got=%b exp=0", seen); end
    issue(4'b0110, 8'h10, 8'h01);
    wait_valid(n);
    checks++;
    if (!out_valid || result !== 8'h0F) begin
      errors++;
      $display("FAIL abort_next got valid=%b res=%h exp res=0f", out_valid, result);
    end
    consume();
  endtask

  initial begin
    test_reset();
    test_add();
    test_ops();
    test_backpressure();
    test_ignore_in_run();
    test_back_to_back();
    test_reset_mid_run();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
